// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and the colour-bar lookup used by
// vga_scan_out when built with VGA_TEST_PATTERN_EN.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START   = H_ACTIVE + H_FP;
  localparam int unsigned HS_END     = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START   = V_ACTIVE + V_FP;
  localparam int unsigned VS_END     = V_ACTIVE + V_FP + V_SYNC;

  localparam int unsigned BAR_WIDTH  = 80;

  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_LUT [0:7] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_LUT[idx];
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Wrapping up-counter 0..MAX with count enable and terminal-count flag.
module vga_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == MAX_C);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_scan_out.sv
// Raster scan generator and registered ADV7123 pin driver for the game display.
// Define VGA_TEST_PATTERN_EN to replace inR/inG/inB with 8 fixed colour bars.
module vga_scan_out #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] px,
  output logic [8:0] py,
  input  logic [7:0] inR,
  input  logic [7:0] inG,
  input  logic [7:0] inB,
  output logic       frame_tick,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HA_C       = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VA_C       = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt, v_cnt;
  logic        h_tc, v_tc_unused;
  logic        h_act, v_act, act;
  logic        hs_raw, vs_raw, tick_d;
  logic [23:0] rgb_d, rgb_q;
  logic        hs_q, vs_q, blank_q, tick_q;

  vga_counter #(.WIDTH(10), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .en_i   (1'b1),
    .cnt_o  (h_cnt),
    .tc_o   (h_tc)
  );

  vga_counter #(.WIDTH(10), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .en_i   (h_tc),
    .cnt_o  (v_cnt),
    .tc_o   (v_tc_unused)
  );

  assign h_act  = (h_cnt < HA_C);
  assign v_act  = (v_cnt < VA_C);
  assign act    = h_act && v_act;
  assign px     = h_act ? h_cnt : '0;
  assign py     = v_act ? v_cnt[8:0] : '0;
  assign hs_raw = !((h_cnt >= HS_START_C) && (h_cnt < HS_END_C));
  assign vs_raw = !((v_cnt >= VS_START_C) && (v_cnt < VS_END_C));
  assign tick_d = (h_cnt == '0) && (v_cnt == VA_C);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  logic       unused_in;
  assign bar_idx   = 3'(h_cnt / 10'(vga_timing_pkg::BAR_WIDTH));
  assign unused_in = ^{inR, inG, inB};

  always_comb begin
    rgb_d = '0;
    if (act) begin
      rgb_d = vga_timing_pkg::bar_colour(bar_idx);
    end
  end
`else
  // Gating with act keeps undriven/X colour during blanking off the pins.
  always_comb begin
    rgb_d = '0;
    if (act) begin
      rgb_d = {inR, inG, inB};
    end
  end
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hs_q    <= hs_raw;
      vs_q    <= vs_raw;
      blank_q <= act;
      tick_q  <= tick_d;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign frame_tick  = tick_q;
  assign VGA_CLK     = ~vga_clk;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_out.sv
// Self-checking bench for vga_scan_out: full 800-clock lines, a shortened
// 30-line frame so two frames fit in a short run; random colour stimulus.
module tb_vga_scan_out;

  localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
  localparam int VA = 24,  VF = 2,  VSW = 2,  VB = 2;
  localparam int HT = HA + HF + HSW + HB;   // 800
  localparam int VT = VA + VF + VSW + VB;   // 30
  localparam int FT = HT * VT;              // 24000

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] inR = '0, inG = '0, inB = '0;
  logic [9:0] px;
  logic [8:0] py;
  logic       frame_tick, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .px          (px),
    .py          (py),
    .inR         (inR),
    .inG         (inG),
    .inB         (inB),
    .frame_tick  (frame_tick),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #20 vga_clk = ~vga_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned n = 0;  // clock edges seen since reset release

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  function automatic logic [23:0] bar(input int idx);
    case (idx)
      0: return {8'hFF, 8'hFF, 8'hFF};  // white
      1: return {8'hFF, 8'hFF, 8'h00};  // yellow
      2: return {8'h00, 8'hFF, 8'hFF};  // cyan
      3: return {8'h00, 8'hFF, 8'h00};  // green
      4: return {8'hFF, 8'h00, 8'hFF};  // magenta
      5: return {8'hFF, 8'h00, 8'h00};  // red
      6: return {8'h00, 8'h00, 8'hFF};  // blue
      default: return 24'h000000;       // black
    endcase
  endfunction

  always @(posedge vga_clk) begin
    if (!reset_n) n = 0;
    else          n = n + 1;
  end

  logic [23:0] drv_last = '0;
  bit          hs_prev = 1'b1, vs_prev = 1'b1;
  int          hs_fall = -1, vs_fall = -1, last_tick = -1;

  always @(negedge vga_clk) begin
    int cur, h, v, prev, hp, vp, sel;
    bit actp, act_now;
    logic [23:0] exp_rgb, nxt;
    cur = int'(n % FT);
    h = cur % HT;
    v = cur / HT;
    if (!reset_n || n == 0) begin
      chk("rst_rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
      chk("rst_hs",    VGA_HS, 1);
      chk("rst_vs",    VGA_VS, 1);
      chk("rst_blank", VGA_BLANK_N, 0);
      chk("rst_tick",  frame_tick, 0);
      chk("rst_px",    px, 0);
      chk("rst_py",    py, 0);
      hs_prev = 1'b1; vs_prev = 1'b1;
      hs_fall = -1; vs_fall = -1; last_tick = -1;
    end else begin
      prev = int'((n - 1) % FT);
      hp = prev % HT;
      vp = prev / HT;
      actp = (hp < HA) && (vp < VA);
`ifdef VGA_TEST_PATTERN_EN
      exp_rgb = actp ? bar(hp / 80) : 24'h0;
`else
      exp_rgb = actp ? drv_last : 24'h0;
`endif
      chk("px",    px, (h < HA) ? h : 0);
      chk("py",    py, (v < VA) ? v : 0);
      chk("rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_rgb});
      chk("hs",    VGA_HS, !(hp >= HA + HF && hp < HA + HF + HSW));
      chk("vs",    VGA_VS, !(vp >= VA + VF && vp < VA + VF + VSW));
      chk("blank", VGA_BLANK_N, actp);
      chk("tick",  frame_tick, (hp == 0 && vp == VA));
      chk("sync_n", VGA_SYNC_N, 0);

      if (h == 640 && v == 10) chk("px_hblank", px, 0);
      if (h == 5 && v == VA)   chk("py_vblank", py, 0);
      if ((hp == 640 && vp == 10) || (hp == 5 && vp == VA)) begin
        chk("blank_edge_n", VGA_BLANK_N, 0);
        chk("blank_edge_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
      end
`ifdef VGA_TEST_PATTERN_EN
      if (vp == 3 && hp == 0)   chk("bar_px0",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
      if (vp == 3 && hp == 400) chk("bar_px400", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFF0000);
      if (vp == 3 && hp == 639) chk("bar_px639", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000000);
`else
      if (hp == 100 && vp == 20 && ((n - 1) / FT) % 2 == 1) begin
        chk("pix100_r", VGA_R, 100);
        chk("pix100_g", VGA_G, 20);
        chk("pix100_b", VGA_B, 8'h5A);
        chk("pix100_blank", VGA_BLANK_N, 1);
      end
`endif
      if (hs_prev && !VGA_HS) begin
        if (hs_fall < 0) chk("hs_first_fall", n, 657);
        else             chk("hs_period", n - hs_fall, 800);
        hs_fall = int'(n);
      end
      if (!hs_prev && VGA_HS && hs_fall >= 0) chk("hs_low_width", n - hs_fall, 96);
      if (vs_prev && !VGA_VS) begin
        if (vs_fall >= 0) chk("vs_period", n - vs_fall, FT);
        vs_fall = int'(n);
      end
      if (!vs_prev && VGA_VS && vs_fall >= 0) chk("vs_low_width", n - vs_fall, 1600);
      if (frame_tick) begin
        if (last_tick < 0) chk("tick_first", n, 19201);
        else               chk("tick_period", n - last_tick, FT);
        last_tick = int'(n);
      end
      hs_prev = VGA_HS;
      vs_prev = VGA_VS;
    end

    act_now = (h < HA) && (v < VA);
    sel = int'($urandom_range(2));
    if (!act_now && sel == 0) begin
      inR = 'x; inG = 'x; inB = 'x;
      drv_last = 24'h0;
    end else begin
      if (!act_now && sel == 1)      nxt = 24'hFFFFFF;
      else if ((n / FT) % 2 == 1)    nxt = {h[7:0], v[7:0], 8'h5A};
      else                           nxt = 24'($urandom);
      {inR, inG, inB} = nxt;
      drv_last = nxt;
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (2 * FT + 50) @(negedge vga_clk);

    found = 1'b0;
    for (int i = 0; i < FT + 10 && !found; i++) begin
      @(negedge vga_clk);
      if (n % FT == 20 * HT + 300) found = 1'b1;
    end
    chk("reach_300_20", found, 1);

    #5 reset_n = 1'b0;
    #1;
    chk("async_rgb",   {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("async_hs",    VGA_HS, 1);
    chk("async_vs",    VGA_VS, 1);
    chk("async_blank", VGA_BLANK_N, 0);
    chk("async_tick",  frame_tick, 0);
    chk("async_px",    px, 0);
    chk("async_py",    py, 0);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (900) @(negedge vga_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
